cnn16_mem_ctrl: RTL and testbench

CNN16_MEM_CTRL -- requirements
Module: cnn16_mem_ctrl

---
 rtl/cnn16_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cnn16_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn16_mem_ctrl.sv
// cnn16_mem_ctrl: single-port word memory with a wait-state access FSM.
// Ports:
//   clk, reset (sync, active-high)
//   req, write_en, address, to_memory, par_inject: request, captured at accept
//   from_memory: read data, registered, held between reads
//   mem_ready: completion pulse; busy: access is in wait states
//   addr_err, parity_err: status, valid with mem_ready
// Optional feature: define CNN16_MEM_PARITY_EN for one even-parity bit per word.
module cnn16_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] to_memory,
  input  logic              par_inject,
  output logic [DATA_W-1:0] from_memory,
  output logic              mem_ready,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZERO_WS = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_fin;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_inrange;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept = req &&
    (r_state == ST_IDLE || r_state == ST_DONE);

  // With no wait states the access completes on the
  // accept edge itself, so it uses the live inputs.
  assign w_fin = ZERO_WS ? w_accept :
    (r_state == ST_WAIT && r_cnt == 4'd0);

  assign w_we    = ZERO_WS ? write_en  : r_we;
  assign w_addr  = ZERO_WS ? address   : r_addr;
  assign w_wdata = ZERO_WS ? to_memory : r_wdata;

  assign w_inrange = {1'b0, w_addr} < DEPTH_W;
  assign w_idx     = w_addr[IDX_W-1:0];
  assign w_rdata   = r_mem[w_idx];

`ifdef CNN16_MEM_PARITY_EN
  logic          r_inj;
  logic          r_par [DEPTH];
  logic          w_inj;
  logic          w_perr;

  assign w_inj  = ZERO_WS ? par_inject : r_inj;
  assign w_perr = (^w_rdata) != r_par[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inj      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (w_accept) r_inj <= par_inject;
      parity_err <= w_fin && !w_we &&
        w_inrange && w_perr;
    end
  end

  // Parity bits are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && w_fin && w_we && w_inrange)
      r_par[w_idx] <= (^w_wdata) ^ w_inj;
  end
`else
  logic w_unused_inj;

  assign w_unused_inj = par_inject;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      from_memory <= '0;
      mem_ready   <= 1'b0;
      busy        <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      addr_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            r_we    <= write_en;
            r_addr  <= address;
            r_wdata <= to_memory;
            if (ZERO_WS) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
              busy    <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
      if (w_fin) begin
        mem_ready <= 1'b1;
        addr_err  <= !w_inrange;
        // Out-of-range reads complete with zero data.
        if (!w_we)
          from_memory <= w_inrange ? w_rdata : '0;
      end
    end
  end

  // Array is never reset; a write lands only on the
  // edge that completes the access.
  always_ff @(posedge clk) begin
    if (!reset && w_fin && w_we && w_inrange)
      r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// Bench for cnn16_mem_ctrl: two instances (0 and 3 wait states),
// randomized traffic against a queue-based reference model.
module tb_cnn16_mem_ctrl;

  localparam int DA  = 16;
  localparam int DB  = 4096;
  localparam int WSB = 3;
`ifdef CNN16_MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstA, reqA, weA, injA;
  logic [11:0] adA;
  logic [15:0] dA, qA;
  logic        rdyA, bzA, aeA, peA;

  logic        rstB, reqB, weB, injB;
  logic [11:0] adB;
  logic [15:0] dB, qB;
  logic        rdyB, bzB, aeB, peB;

  cnn16_mem_ctrl #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(DA), .WAIT_STATES(0)
  ) u_a (
    .clk(clk), .reset(rstA), .req(reqA), .write_en(weA),
    .address(adA), .to_memory(dA), .par_inject(injA),
    .from_memory(qA), .mem_ready(rdyA), .busy(bzA),
    .addr_err(aeA), .parity_err(peA)
  );

  cnn16_mem_ctrl #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(DB), .WAIT_STATES(WSB)
  ) u_b (
    .clk(clk), .reset(rstB), .req(reqB), .write_en(weB),
    .address(adB), .to_memory(dB), .par_inject(injB),
    .from_memory(qB), .mem_ready(rdyB), .busy(bzB),
    .addr_err(aeB), .parity_err(peB)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        ae;
    logic        pe;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Model memories: {stored inject bit, data}.
  logic [16:0] mA [int];
  logic [16:0] mB [int];
  logic [15:0] lastA = 16'h0;
  logic [15:0] lastB = 16'h0;

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (!rstA && rdyA) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL A unexpected mem_ready at cycle %0d", cyc);
      end else begin
        ea = qa.pop_front();
        chk("A from_memory", qA, ea.d);
        chk("A addr_err", aeA, ea.ae);
        chk("A parity_err", peA, ea.pe);
        chk("A latency", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rstB && rdyB) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL B unexpected mem_ready at cycle %0d", cyc);
      end else begin
        eb = qb.pop_front();
        chk("B from_memory", qB, eb.d);
        chk("B addr_err", aeB, eb.ae);
        chk("B parity_err", peB, eb.pe);
        chk("B latency", cyc, eb.cyc);
      end
    end
  end

  // Issue on A at a negedge; returns at the next negedge.
  task automatic a_access(bit we, int addr,
                          logic [15:0] d, bit inj);
    exp_t e;
    reqA = 1'b1; weA = we; adA = addr[11:0];
    dA = d; injA = inj;
    e.cyc = cyc + 1;
    e.ae  = (addr >= DA);
    e.pe  = 1'b0;
    if (we) begin
      if (!e.ae) mA[addr] = {inj, d};
      e.d = lastA;
    end else begin
      if (e.ae) begin
        e.d = 16'h0;
      end else begin
        e.d  = mA[addr][15:0];
        e.pe = PAR & mA[addr][16];
      end
      lastA = e.d;
    end
    qa.push_back(e);
    @(negedge clk);
  endtask

  // Issue on B; returns at the negedge of its DONE cycle.
  // With junk set, req stays high during the wait states.
  task automatic b_access(bit we, int addr,
                          logic [15:0] d, bit inj, bit junk);
    exp_t e;
    reqB = 1'b1; weB = we; adB = addr[11:0];
    dB = d; injB = inj;
    e.cyc = cyc + 1 + WSB;
    e.ae  = (addr >= DB);
    e.pe  = 1'b0;
    if (we) begin
      if (!e.ae) mB[addr] = {inj, d};
      e.d = lastB;
    end else begin
      if (e.ae) begin
        e.d = 16'h0;
      end else begin
        e.d  = mB[addr][15:0];
        e.pe = PAR & mB[addr][16];
      end
      lastB = e.d;
    end
    qb.push_back(e);
    for (int i = 0; i < WSB; i++) begin
      @(negedge clk);
      chk("B busy in wait", bzB, 1'b1);
      chk("B no early ready", rdyB, 1'b0);
      if (junk) begin
        reqB = 1'b1; weB = 1'b1;
        adB = 12'(addr); dB = 16'hDEAD;
      end else begin
        reqB = 1'b0;
      end
    end
    @(negedge clk);
    reqB = 1'b0;
    chk("B busy in done", bzB, 1'b0);
  endtask

  task automatic chk_reset(string nm, logic [15:0] q,
                           logic r, logic b, logic ae,
                           logic pe);
    chk({nm, " rst from_memory"}, q, 16'h0);
    chk({nm, " rst mem_ready"}, r, 1'b0);
    chk({nm, " rst busy"}, b, 1'b0);
    chk({nm, " rst addr_err"}, ae, 1'b0);
    chk({nm, " rst parity_err"}, pe, 1'b0);
  endtask

  initial begin
    rstA = 1'b1; reqA = 1'b0; weA = 1'b0; adA = '0;
    dA = '0; injA = 1'b0;
    rstB = 1'b1; reqB = 1'b0; weB = 1'b0; adB = '0;
    dB = '0; injB = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("A", qA, rdyA, bzA, aeA, peA);
    chk_reset("B", qB, rdyB, bzB, aeB, peB);
    rstA = 1'b0; rstB = 1'b0;
    @(negedge clk);

    // Basic write then read.
    a_access(1'b1, 0, 16'h1234, 1'b0);
    a_access(1'b0, 0, 16'h0, 1'b0);
    reqA = 1'b0;
    @(negedge clk);

    // Back-to-back stream with req held.
    a_access(1'b1, 1, 16'hA5A5, 1'b0);
    a_access(1'b0, 1, 16'h0, 1'b0);
    a_access(1'b1, 2, 16'h5A5A, 1'b0);
    a_access(1'b0, 2, 16'h0, 1'b0);
    reqA = 1'b0;
    @(negedge clk);

    // Out-of-range write and read; word 0 must survive.
    a_access(1'b1, 16, 16'hBEEF, 1'b0);
    a_access(1'b0, 16, 16'h0, 1'b0);
    a_access(1'b0, 0, 16'h0, 1'b0);
    reqA = 1'b0;
    @(negedge clk);

    // Injected parity error.
    a_access(1'b1, 3, 16'h1111, 1'b1);
    a_access(1'b0, 3, 16'h0, 1'b0);
    reqA = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DA; i++)
      a_access(1'b1, i, 16'($urandom), 1'($urandom));
    for (int i = 0; i < 200; i++) begin
      a_access(1'($urandom), $urandom_range(0, 31),
               16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        reqA = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    reqA = 1'b0;

    // B: wait states, ignored req during busy.
    b_access(1'b1, 3, 16'h0AAA, 1'b0, 1'b0);
    b_access(1'b1, 5, 16'h0BBB, 1'b0, 1'b0);
    b_access(1'b0, 5, 16'h0, 1'b0, 1'b1);
    b_access(1'b0, 5, 16'h0, 1'b0, 1'b0);

    // Reset in the first wait cycle aborts a write.
    reqB = 1'b1; weB = 1'b1; adB = 12'h003; dB = 16'h5678;
    @(negedge clk);
    reqB = 1'b0;
    chk("B busy before abort", bzB, 1'b1);
    rstB = 1'b1;
    @(negedge clk);
    chk_reset("B abort", qB, rdyB, bzB, aeB, peB);
    rstB = 1'b0;
    lastB = 16'h0;
    repeat (WSB + 2) @(negedge clk);
    b_access(1'b0, 3, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int  a;
      bit  w;
      w = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ?
          $urandom_range(0, 15) : $urandom_range(0, DB - 1);
      if (!w && !mB.exists(a)) w = 1'b1;
      b_access(w, a, 16'($urandom), 1'($urandom),
               1'($urandom));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    reqA = 1'b0; reqB = 1'b0;
    repeat (WSB + 4) @(negedge clk);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
